// File: rtl/dot_accum.sv
// Streaming dot-product accumulator: sums N float32 products through an external adder over stb/ack handshakes.
// Optional macro DOT_ACCUM_NAN_FLAG_EN adds a sticky per-vector NaN flag on output_nan.
module dot_accum #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_p,
    input  logic        input_p_stb,
    output logic        input_p_ack,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    output logic        adder_a_stb,
    output logic        adder_b_stb,
    input  logic        adder_a_ack,
    input  logic        adder_b_ack,
    input  logic [31:0] adder_z,
    input  logic        adder_z_stb,
    output logic        adder_z_ack,
    output logic [31:0] output_sum,
    output logic        output_sum_stb,
    input  logic        output_sum_ack
`ifdef DOT_ACCUM_NAN_FLAG_EN
    ,
    output logic        output_nan
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {GET_P, SEND_AB, WAIT_Z, PUT_SUM} state_t;

    state_t        state, state_d;
    logic [31:0]   acc, acc_d;
    logic [CW-1:0] count, count_d;
    logic          p_ack_d, a_stb_d, b_stb_d, z_ack_d, sum_stb_d;
    logic [31:0]   a_d, b_d, sum_d;
    logic          a_done, b_done;

`ifdef DOT_ACCUM_NAN_FLAG_EN
    logic nan_r, nan_d;
    assign output_nan = nan_r;
`endif

    // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d   = state;
        acc_d     = acc;
        count_d   = count;
        p_ack_d   = input_p_ack;
        a_d       = adder_a;
        b_d       = adder_b;
        a_stb_d   = adder_a_stb;
        b_stb_d   = adder_b_stb;
        z_ack_d   = adder_z_ack;
        sum_d     = output_sum;
        sum_stb_d = output_sum_stb;
        a_done    = !adder_a_stb || adder_a_ack;
        b_done    = !adder_b_stb || adder_b_ack;
`ifdef DOT_ACCUM_NAN_FLAG_EN
        nan_d     = nan_r;
`endif
        case (state)
            GET_P: begin
                if (input_p_ack && input_p_stb) begin
                    p_ack_d = 1'b0;
                    a_d     = acc;
                    b_d     = input_p;
                    a_stb_d = 1'b1;
                    b_stb_d = 1'b1;
                    state_d = SEND_AB;
`ifdef DOT_ACCUM_NAN_FLAG_EN
                    nan_d   = nan_r | ((input_p[30:23] == 8'hFF) && (input_p[22:0] != 23'd0));
`endif
                end else begin
                    p_ack_d = 1'b1;
                end
            end
            SEND_AB: begin
                // Each operand handshake completes on its own; wait for both.
                if (adder_a_stb && adder_a_ack) a_stb_d = 1'b0;
                if (adder_b_stb && adder_b_ack) b_stb_d = 1'b0;
                if (a_done && b_done) begin
                    z_ack_d = 1'b1;
                    state_d = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (adder_z_ack && adder_z_stb) begin
                    acc_d   = adder_z;
                    z_ack_d = 1'b0;
                    if (count == LAST) begin
                        count_d   = '0;
                        sum_d     = adder_z;
                        sum_stb_d = 1'b1;
                        state_d   = PUT_SUM;
                    end else begin
                        count_d = count + CW'(1);
                        p_ack_d = 1'b1;
                        state_d = GET_P;
                    end
                end else begin
                    z_ack_d = 1'b1;
                end
            end
            PUT_SUM: begin
                if (output_sum_stb && output_sum_ack) begin
                    sum_stb_d = 1'b0;
                    acc_d     = 32'h0000_0000;
                    count_d   = '0;
                    p_ack_d   = 1'b1;
                    state_d   = GET_P;
`ifdef DOT_ACCUM_NAN_FLAG_EN
                    nan_d     = 1'b0;
`endif
                end
            end
            default: state_d = GET_P;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= GET_P;
            acc            <= '0;
            count          <= '0;
            input_p_ack    <= 1'b0;
            adder_a        <= '0;
            adder_b        <= '0;
            adder_a_stb    <= 1'b0;
            adder_b_stb    <= 1'b0;
            adder_z_ack    <= 1'b0;
            output_sum     <= '0;
            output_sum_stb <= 1'b0;
`ifdef DOT_ACCUM_NAN_FLAG_EN
            nan_r          <= 1'b0;
`endif
        end else begin
            state          <= state_d;
            acc            <= acc_d;
            count          <= count_d;
            input_p_ack    <= p_ack_d;
            adder_a        <= a_d;
            adder_b        <= b_d;
            adder_a_stb    <= a_stb_d;
            adder_b_stb    <= b_stb_d;
            adder_z_ack    <= z_ack_d;
            output_sum     <= sum_d;
            output_sum_stb <= sum_stb_d;
`ifdef DOT_ACCUM_NAN_FLAG_EN
            nan_r          <= nan_d;
`endif
        end
    end

endmodule

// File: tb/tb_dot_accum.sv
// Directed bench for dot_accum: an N=4 instance with a configurable-delay float adder and an N=1 instance.
// Build with DOT_ACCUM_NAN_FLAG_EN to also exercise the NaN flag.
module tb_dot_accum;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=4 instance signals
    logic [31:0] input_p, adder_a, adder_b, adder_z, output_sum;
    logic input_p_stb, input_p_ack, adder_a_stb, adder_b_stb, adder_a_ack, adder_b_ack;
    logic adder_z_stb, adder_z_ack, output_sum_stb, output_sum_ack;
    // N=1 instance signals
    logic [31:0] input_p1, adder_a1, adder_b1, adder_z1, output_sum1;
    logic input_p_stb1, input_p_ack1, adder_a_stb1, adder_b_stb1, adder_a_ack1, adder_b_ack1;
    logic adder_z_stb1, adder_z_ack1, output_sum_stb1, output_sum_ack1;
`ifdef DOT_ACCUM_NAN_FLAG_EN
    logic output_nan, output_nan1;
`endif

    dot_accum #(.N(4)) dut (
        .clk(clk), .rst(rst),
        .input_p(input_p), .input_p_stb(input_p_stb), .input_p_ack(input_p_ack),
        .adder_a(adder_a), .adder_b(adder_b), .adder_a_stb(adder_a_stb), .adder_b_stb(adder_b_stb),
        .adder_a_ack(adder_a_ack), .adder_b_ack(adder_b_ack),
        .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack),
        .output_sum(output_sum), .output_sum_stb(output_sum_stb), .output_sum_ack(output_sum_ack)
`ifdef DOT_ACCUM_NAN_FLAG_EN
        , .output_nan(output_nan)
`endif
    );

    dot_accum #(.N(1)) dut1 (
        .clk(clk), .rst(rst),
        .input_p(input_p1), .input_p_stb(input_p_stb1), .input_p_ack(input_p_ack1),
        .adder_a(adder_a1), .adder_b(adder_b1), .adder_a_stb(adder_a_stb1), .adder_b_stb(adder_b_stb1),
        .adder_a_ack(adder_a_ack1), .adder_b_ack(adder_b_ack1),
        .adder_z(adder_z1), .adder_z_stb(adder_z_stb1), .adder_z_ack(adder_z_ack1),
        .output_sum(output_sum1), .output_sum_stb(output_sum_stb1), .output_sum_ack(output_sum_ack1)
`ifdef DOT_ACCUM_NAN_FLAG_EN
        , .output_nan(output_nan1)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Float helpers for the adder stand-in (normals and zero are enough here).
    function automatic real f2r(input logic [31:0] f);
        if (f[30:0] == 31'd0) return 0.0;
        return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) return 32'h7FC0_0000;
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Adder stand-in for the N=4 instance with separate a/b ack delays and z delay.
    int a_wait = 0, b_wait = 0, z_wait = 0;
    initial begin : adder4
        int wa, wb;
        logic got_a, got_b;
        logic [31:0] av, bv;
        adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0; adder_z = '0;
        av = '0; bv = '0;
        forever begin
            @(negedge clk);
            if (adder_a_stb && adder_b_stb && !rst) begin
                wa = a_wait; wb = b_wait; got_a = 1'b0; got_b = 1'b0;
                while (!(got_a && got_b)) begin
                    adder_a_ack = 1'b0;
                    adder_b_ack = 1'b0;
                    if (!got_a && wa == 0) begin adder_a_ack = 1'b1; got_a = 1'b1; av = adder_a; end
                    if (!got_b && wb == 0) begin adder_b_ack = 1'b1; got_b = 1'b1; bv = adder_b; end
                    if (wa > 0) wa--;
                    if (wb > 0) wb--;
                    @(negedge clk);
                end
                adder_a_ack = 1'b0;
                adder_b_ack = 1'b0;
                repeat (z_wait) @(negedge clk);
                adder_z = fadd(av, bv);
                adder_z_stb = 1'b1;
                @(negedge clk);
                adder_z_stb = 1'b0;
            end
        end
    end

    // Zero-wait adder stand-in for the N=1 instance.
    initial begin : adder1
        logic [31:0] av1, bv1;
        adder_a_ack1 = 1'b0; adder_b_ack1 = 1'b0; adder_z_stb1 = 1'b0; adder_z1 = '0;
        av1 = '0; bv1 = '0;
        forever begin
            @(negedge clk);
            adder_a_ack1 = adder_a_stb1;
            adder_b_ack1 = adder_b_stb1;
            if (adder_a_stb1) av1 = adder_a1;
            if (adder_b_stb1) bv1 = adder_b1;
            adder_z_stb1 = adder_z_ack1 && !adder_z_stb1;
            adder_z1 = fadd(av1, bv1);
        end
    end

    int sum_xfers = 0, z_xfers1 = 0;
    always @(posedge clk) begin
        if (output_sum_stb && output_sum_ack) sum_xfers++;
        if (adder_z_stb1 && adder_z_ack1) z_xfers1++;
    end

    task automatic send_p(input logic [31:0] v);
        input_p = v;
        input_p_stb = 1'b1;
        for (int i = 0; i < 200 && !input_p_ack; i++) @(negedge clk);
        if (!input_p_ack) check("p_ack_timeout", 32'd0, 32'd1);
        @(negedge clk);
        input_p_stb = 1'b0;
    endtask

    task automatic wait_sum();
        for (int i = 0; i < 300 && !output_sum_stb; i++) @(negedge clk);
        if (!output_sum_stb) check("sum_timeout", 32'd0, 32'd1);
    endtask

    logic nan_seen;
    task automatic get_sum(output logic [31:0] v);
        wait_sum();
        v = output_sum;
`ifdef DOT_ACCUM_NAN_FLAG_EN
        nan_seen = output_nan;
`endif
        output_sum_ack = 1'b1;
        @(negedge clk);
        output_sum_ack = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] p0, p1, p2, p3);
        send_p(p0); send_p(p1); send_p(p2); send_p(p3);
    endtask

    logic [31:0] s, held;
    logic stable;
    initial begin
        rst = 1'b1;
        input_p = '0; input_p_stb = 1'b0; output_sum_ack = 1'b0;
        input_p1 = '0; input_p_stb1 = 1'b0; output_sum_ack1 = 1'b0;
        nan_seen = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p_ack", 32'(input_p_ack), 32'd0);
        check("rst_a_stb", 32'(adder_a_stb), 32'd0);
        check("rst_b_stb", 32'(adder_b_stb), 32'd0);
        check("rst_z_ack", 32'(adder_z_ack), 32'd0);
        check("rst_sum_stb", 32'(output_sum_stb), 32'd0);
        check("rst_sum", output_sum, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("p_ack_rise", 32'(input_p_ack), 32'd1);

        // Four ones, zero-wait neighbours.
        sum_xfers = 0;
        send_vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        get_sum(s);
        check("sum_ones", s, 32'h4080_0000);
        repeat (5) @(negedge clk);
        check("one_xfer", 32'(sum_xfers), 32'd1);

        // 1+2+3+4 with staggered operand acks and slow z.
        a_wait = 0; b_wait = 2; z_wait = 5;
        send_vec(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        get_sum(s);
        check("sum_1234", s, 32'h4120_0000);
        a_wait = 0; b_wait = 0; z_wait = 0;

        // Back-pressure on the sum for 20 cycles.
        send_vec(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        wait_sum();
        held = output_sum;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!output_sum_stb || output_sum !== held || input_p_ack) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        get_sum(s);
        check("bp_sum", s, 32'h4100_0000);
        send_vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        get_sum(s);
        check("after_bp", s, 32'h4080_0000);

        // Reset one cycle after the second product of a vector.
        send_p(32'h3F80_0000);
        send_p(32'h3F80_0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_p_ack", 32'(input_p_ack), 32'd0);
        check("mid_rst_a_stb", 32'(adder_a_stb), 32'd0);
        check("mid_rst_b_stb", 32'(adder_b_stb), 32'd0);
        check("mid_rst_z_ack", 32'(adder_z_ack), 32'd0);
        check("mid_rst_sum_stb", 32'(output_sum_stb), 32'd0);
        send_vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        get_sum(s);
        check("after_rst", s, 32'h4080_0000);

        // N=1: single add of -2.0 onto +0.0.
        z_xfers1 = 0;
        input_p1 = 32'hC000_0000;
        input_p_stb1 = 1'b1;
        for (int i = 0; i < 200 && !input_p_ack1; i++) @(negedge clk);
        if (!input_p_ack1) check("n1_p_ack_timeout", 32'd0, 32'd1);
        @(negedge clk);
        input_p_stb1 = 1'b0;
        for (int i = 0; i < 200 && !output_sum_stb1; i++) @(negedge clk);
        check("n1_sum_stb", 32'(output_sum_stb1), 32'd1);
        check("n1_sum", output_sum1, 32'hC000_0000);
        check("n1_one_add", 32'(z_xfers1), 32'd1);
        output_sum_ack1 = 1'b1;
        @(negedge clk);
        output_sum_ack1 = 1'b0;

`ifdef DOT_ACCUM_NAN_FLAG_EN
        send_vec(32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'h3F80_0000);
        get_sum(s);
        check("nan_set", 32'(nan_seen), 32'd1);
        send_vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        get_sum(s);
        check("nan_clear", 32'(nan_seen), 32'd0);
        check("nan_next_sum", s, 32'h4080_0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
